// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID/EX bus; master drives id_*/id_valid/ex_hold/flush and reads ex_*/stall_o, slave (the stage) is the reverse
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W = 5
);
  logic id_RegDst, id_J, id_Beq, id_Bneq, id_MemRead, id_MemtoReg, id_MemWrite, id_RegWrite;
  logic [1:0] id_Alu_src;
  logic [2:0] id_Alu_op;
  logic [DATA_W-1:0] id_pc4, id_rs_data, id_rt_data;
  logic [15:0] id_imm;
  logic [REG_W-1:0] id_rs, id_rt, id_rd;
  logic id_valid, ex_hold, flush;
  logic ex_RegDst, ex_J, ex_Beq, ex_Bneq, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_RegWrite;
  logic [1:0] ex_Alu_src;
  logic [2:0] ex_Alu_op;
  logic [DATA_W-1:0] ex_pc4, ex_rs_data, ex_rt_data;
  logic [15:0] ex_imm;
  logic [REG_W-1:0] ex_rs, ex_rt, ex_rd;
  logic ex_valid, stall_o;
  modport master (
    output id_RegDst, id_J, id_Beq, id_Bneq, id_MemRead, id_MemtoReg, id_MemWrite, id_RegWrite,
    output id_Alu_src, id_Alu_op, id_pc4, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
    output id_valid, ex_hold, flush,
    input ex_RegDst, ex_J, ex_Beq, ex_Bneq, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_RegWrite,
    input ex_Alu_src, ex_Alu_op, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd,
    input ex_valid, stall_o
  );
  modport slave (
    input id_RegDst, id_J, id_Beq, id_Bneq, id_MemRead, id_MemtoReg, id_MemWrite, id_RegWrite,
    input id_Alu_src, id_Alu_op, id_pc4, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
    input id_valid, ex_hold, flush,
    output ex_RegDst, ex_J, ex_Beq, ex_Bneq, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_RegWrite,
    output ex_Alu_src, ex_Alu_op, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd,
    output ex_valid, stall_o
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX register with rst>flush>hold>load-use bubble>capture, stall_o combinational (hazard logic only under LOAD_USE_STALL_EN); ports clk, rst, p (id_ex_stage_if.slave)
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W = 5
) (
  input logic clk,
  input logic rst,
  id_ex_stage_if.slave p
);
  localparam int W = 14 + 3 * DATA_W + 16 + 3 * REG_W;
  logic [W-1:0] id_bus, ex_bus;
  logic hazard;
  assign id_bus = {p.id_RegDst, p.id_J, p.id_Beq, p.id_Bneq, p.id_MemRead, p.id_MemtoReg,
                   p.id_MemWrite, p.id_RegWrite, p.id_Alu_src, p.id_Alu_op, p.id_pc4,
                   p.id_rs_data, p.id_rt_data, p.id_imm, p.id_rs, p.id_rt, p.id_rd, p.id_valid};
  assign {p.ex_RegDst, p.ex_J, p.ex_Beq, p.ex_Bneq, p.ex_MemRead, p.ex_MemtoReg,
          p.ex_MemWrite, p.ex_RegWrite, p.ex_Alu_src, p.ex_Alu_op, p.ex_pc4,
          p.ex_rs_data, p.ex_rt_data, p.ex_imm, p.ex_rs, p.ex_rt, p.ex_rd, p.ex_valid} = ex_bus;
`ifdef LOAD_USE_STALL_EN
  assign hazard = p.ex_valid & p.ex_MemRead & p.id_valid & (p.ex_rt != '0) &
                  ((p.ex_rt == p.id_rs) | (p.ex_rt == p.id_rt));
`else
  assign hazard = 1'b0;
`endif
  assign p.stall_o = hazard;
  always_ff @(posedge clk)
    if (rst || p.flush) ex_bus <= '0;
    else if (!p.ex_hold) ex_bus <= hazard ? '0 : id_bus;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors with a queued scoreboard checking stall_o and the ex_* registers
module tb_id_ex_stage;
`ifdef LOAD_USE_STALL_EN
  localparam logic LU = 1'b1;
`else
  localparam logic LU = 1'b0;
`endif
  typedef struct packed {
    logic regdst, j, beq, bneq, memread, memtoreg, memwrite, regwrite;
    logic [1:0] alu_src;
    logic [2:0] alu_op;
    logic [31:0] pc4, rs_data, rt_data;
    logic [15:0] imm;
    logic [4:0] rs, rt, rd;
    logic valid;
  } vec_t;
  typedef struct {
    vec_t ex;
    logic st;
    string nm;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  exp_t q[$];
  exp_t me;
  vec_t model;
  int checks = 0;
  int fails = 0;
  id_ex_stage_if p ();
  id_ex_stage dut (.clk(clk), .rst(rst), .p(p));
  always #5 clk = ~clk;
  function automatic vec_t ex_now();
    vec_t v;
    v = {p.ex_RegDst, p.ex_J, p.ex_Beq, p.ex_Bneq, p.ex_MemRead, p.ex_MemtoReg,
         p.ex_MemWrite, p.ex_RegWrite, p.ex_Alu_src, p.ex_Alu_op, p.ex_pc4,
         p.ex_rs_data, p.ex_rt_data, p.ex_imm, p.ex_rs, p.ex_rt, p.ex_rd, p.ex_valid};
    return v;
  endfunction
  task automatic drive(input vec_t v);
    {p.id_RegDst, p.id_J, p.id_Beq, p.id_Bneq, p.id_MemRead, p.id_MemtoReg,
     p.id_MemWrite, p.id_RegWrite, p.id_Alu_src, p.id_Alu_op, p.id_pc4,
     p.id_rs_data, p.id_rt_data, p.id_imm, p.id_rs, p.id_rt, p.id_rd, p.id_valid} = v;
  endtask
  function automatic vec_t rtype(input logic [4:0] rs, rt, rd, input logic [31:0] rsd);
    vec_t v;
    v = '0;
    v.regdst = 1'b1;
    v.regwrite = 1'b1;
    v.alu_op = 3'b010;
    v.pc4 = 32'h0040_0010;
    v.rs = rs;
    v.rt = rt;
    v.rd = rd;
    v.rs_data = rsd;
    v.rt_data = ~rsd;
    v.imm = {rd, 11'h020};
    v.valid = 1'b1;
    return v;
  endfunction
  function automatic vec_t lw(input logic [4:0] rs, rt, input logic [15:0] imm);
    vec_t v;
    v = '0;
    v.memread = 1'b1;
    v.memtoreg = 1'b1;
    v.regwrite = 1'b1;
    v.alu_src = 2'b01;
    v.pc4 = 32'h0040_0020;
    v.rs = rs;
    v.rt = rt;
    v.imm = imm;
    v.rs_data = 32'h0000_1000;
    v.valid = 1'b1;
    return v;
  endfunction
  function automatic vec_t sw(input logic [4:0] rs, rt, input logic [15:0] imm);
    vec_t v;
    v = '0;
    v.memwrite = 1'b1;
    v.alu_src = 2'b01;
    v.pc4 = 32'h0040_0030;
    v.rs = rs;
    v.rt = rt;
    v.imm = imm;
    v.rs_data = 32'h0000_2000;
    v.rt_data = 32'hdead_beef;
    v.valid = 1'b1;
    return v;
  endfunction
  // st is the hand-computed stall for this cycle; the register outcome follows rst>flush>hold>bubble>capture
  task automatic step(input vec_t v, input logic r, h, f, st, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    p.ex_hold = h;
    p.flush = f;
    drive(v);
    model = (r || f) ? '0 : h ? model : st ? '0 : v;
    e.ex = model;
    e.st = st;
    e.nm = nm;
    q.push_back(e);
  endtask
  initial forever begin
    @(negedge clk);
    if (q.size() != 0) begin
      me = q.pop_front();
      checks++;
      if (p.stall_o !== me.st) begin
        fails++;
        $display("FAIL %s stall_o got %b want %b", me.nm, p.stall_o, me.st);
      end
      @(posedge clk);
      #2;
      checks++;
      if (ex_now() !== me.ex) begin
        fails++;
        $display("FAIL %s ex got %h want %h", me.nm, ex_now(), me.ex);
      end
    end
  end
  initial begin
    vec_t ones, lw3, add3, addrt, nv;
    ones = '1;
    lw3 = lw(5'd1, 5'd3, 16'd0);
    add3 = rtype(5'd3, 5'd2, 5'd4, 32'h0000_0011);
    addrt = rtype(5'd2, 5'd3, 5'd7, 32'h0000_0044);
    rst = 1'b1;
    p.ex_hold = 1'b0;
    p.flush = 1'b0;
    drive(ones);
    model = '0;
    repeat (2) @(posedge clk);
    step(ones, 1, 0, 0, 0, "reset_a");
    step(ones, 1, 0, 0, 0, "reset_b");
    step(rtype(5'd1, 5'd2, 5'd5, 32'h1234_5678), 0, 0, 0, 0, "capture_rtype");
    step(lw3, 0, 0, 0, 0, "lw3_a");
    step(add3, 0, 0, 0, LU, "loaduse_stall");
    step(add3, 0, 0, 0, 0, "loaduse_retry");
    step(lw(5'd1, 5'd0, 16'd4), 0, 0, 0, 0, "lw0");
    step(rtype(5'd0, 5'd0, 5'd4, 32'h0000_0022), 0, 0, 0, 0, "no_stall_r0");
    step(lw3, 0, 0, 0, 0, "lw3_b");
    step(rtype(5'd5, 5'd6, 5'd4, 32'h0000_0033), 0, 0, 0, 0, "no_stall_indep");
    step(lw3, 0, 0, 0, 0, "lw3_c");
    step(addrt, 0, 0, 0, LU, "stall_rt_match");
    step(addrt, 0, 0, 0, 0, "rt_retry");
    step(lw3, 0, 0, 0, 0, "lw3_d");
    step(add3, 0, 1, 0, LU, "hold_hazard_a");
    step(add3, 0, 1, 0, LU, "hold_hazard_b");
    step(add3, 0, 0, 1, LU, "flush_hazard");
    step(sw(5'd1, 5'd2, 16'd8), 0, 1, 1, 0, "flush_over_hold");
    step(sw(5'd1, 5'd2, 16'd8), 0, 0, 0, 0, "sw_capture");
    step(add3, 0, 1, 0, 0, "hold_1");
    step(lw3, 0, 1, 0, 0, "hold_2");
    step(ones, 0, 1, 0, 0, "hold_3");
    step(lw3, 0, 0, 0, 0, "lw3_e");
    step(add3, 1, 0, 0, LU, "reset_mid_stall");
    step(add3, 0, 0, 0, 0, "after_reset");
    step(lw3, 0, 0, 0, 0, "lw3_f");
    nv = add3;
    nv.valid = 1'b0;
    step(nv, 0, 0, 0, 0, "invalid_id_no_stall");
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain pending got %0d want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
